// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep scheduler feeding the sine_dds frequency control word.
// Steps fcw from start toward stop, holding each value for a dwell period.
module dds_sweep_ctrl #(
    parameter int FCW_W   = 24,
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [1:0]         mode,
    input  logic [FCW_W-1:0]   fcw_start,
    input  logic [FCW_W-1:0]   fcw_stop,
    input  logic [FCW_W-1:0]   fcw_step,
    input  logic [DWELL_W-1:0] dwell,
    output logic [FCW_W-1:0]   fcw,
    output logic               busy,
    output logic               done,
    output logic               step_tick
);

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    state_e             state_q, state_d;
    logic [FCW_W-1:0]   fcw_q, fcw_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               tick_q, tick_d;
    logic [1:0]         mode_q, mode_d;
    logic [FCW_W-1:0]   start_q, start_d;
    logic [FCW_W-1:0]   stop_q, stop_d;
    logic [FCW_W-1:0]   step_q, step_d;
    logic [FCW_W-1:0]   tgt_q, tgt_d;
    logic               tgt_is_stop_q, tgt_is_stop_d;
    logic               up_q, up_d;
    logic [DWELL_W-1:0] dwm1_q, dwm1_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [FCW_W-1:0]   pp_tgt;

    // Saturating step toward tgt: any overshoot or wrap lands exactly on tgt.
    function automatic logic [FCW_W-1:0] step_to(
        input logic [FCW_W-1:0] cur,
        input logic [FCW_W-1:0] tgt,
        input logic [FCW_W-1:0] stp,
        input logic             up
    );
        logic [FCW_W:0]   sum;
        logic [FCW_W:0]   dif;
        logic [FCW_W-1:0] r;
        sum = {1'b0, cur} + {1'b0, stp};
        dif = {1'b0, cur} - {1'b0, stp};
        if (stp == '0) begin
            r = tgt;
        end else if (up) begin
            r = (sum[FCW_W] || sum[FCW_W-1:0] >= tgt) ? tgt : sum[FCW_W-1:0];
        end else begin
            r = (dif[FCW_W] || dif[FCW_W-1:0] <= tgt) ? tgt : dif[FCW_W-1:0];
        end
        return r;
    endfunction

    assign pp_tgt = tgt_is_stop_q ? start_q : stop_q;

    always_comb begin
        state_d       = state_q;
        fcw_d         = fcw_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        tick_d        = 1'b0;
        mode_d        = mode_q;
        start_d       = start_q;
        stop_d        = stop_q;
        step_d        = step_q;
        tgt_d         = tgt_q;
        tgt_is_stop_d = tgt_is_stop_q;
        up_d          = up_q;
        dwm1_d        = dwm1_q;
        cnt_d         = cnt_q;
        if (abort) begin
            state_d = IDLE;
            fcw_d   = '0;
            busy_d  = 1'b0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d       = RUN;
                        mode_d        = (mode == 2'b11) ? 2'b00 : mode;
                        start_d       = fcw_start;
                        stop_d        = fcw_stop;
                        step_d        = fcw_step;
                        tgt_d         = fcw_stop;
                        tgt_is_stop_d = 1'b1;
                        up_d          = (fcw_start <= fcw_stop);
                        dwm1_d        = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
                        cnt_d         = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
                        fcw_d         = fcw_start;
                        busy_d        = 1'b1;
                        tick_d        = 1'b1;
                    end
                end
                RUN: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - DWELL_W'(1);
                    end else begin
                        cnt_d  = dwm1_q;
                        tick_d = 1'b1;
                        if (fcw_q != tgt_q) begin
                            fcw_d = step_to(fcw_q, tgt_q, step_q, up_q);
                        end else begin
                            unique case (mode_q)
                                2'b01: fcw_d = start_q;
                                2'b10: begin
                                    // Turn around immediately so endpoints are not repeated.
                                    tgt_d         = pp_tgt;
                                    tgt_is_stop_d = ~tgt_is_stop_q;
                                    up_d          = ~up_q;
                                    fcw_d         = step_to(fcw_q, pp_tgt, step_q, ~up_q);
                                end
                                default: begin
                                    state_d = IDLE;
                                    busy_d  = 1'b0;
                                    done_d  = 1'b1;
                                    tick_d  = 1'b0;
                                end
                            endcase
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            fcw_q         <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            tick_q        <= 1'b0;
            mode_q        <= '0;
            start_q       <= '0;
            stop_q        <= '0;
            step_q        <= '0;
            tgt_q         <= '0;
            tgt_is_stop_q <= 1'b0;
            up_q          <= 1'b0;
            dwm1_q        <= '0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            fcw_q         <= fcw_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            tick_q        <= tick_d;
            mode_q        <= mode_d;
            start_q       <= start_d;
            stop_q        <= stop_d;
            step_q        <= step_d;
            tgt_q         <= tgt_d;
            tgt_is_stop_q <= tgt_is_stop_d;
            up_q          <= up_d;
            dwm1_q        <= dwm1_d;
            cnt_q         <= cnt_d;
        end
    end

    assign fcw       = fcw_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign step_tick = tick_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed table-driven bench for dds_sweep_ctrl.
// Each record lists sweep settings and the expected fcw sequence.
module tb_dds_sweep_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [1:0]  mode = '0;
    logic [23:0] fcw_start = '0;
    logic [23:0] fcw_stop = '0;
    logic [23:0] fcw_step = '0;
    logic [15:0] dwell = '0;
    logic [23:0] fcw;
    logic        busy;
    logic        done;
    logic        step_tick;

    int ncmp = 0;
    int nfail = 0;

    dds_sweep_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .mode      (mode),
        .fcw_start (fcw_start),
        .fcw_stop  (fcw_stop),
        .fcw_step  (fcw_step),
        .dwell     (dwell),
        .fcw       (fcw),
        .busy      (busy),
        .done      (done),
        .step_tick (step_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]       mode;
        logic [23:0]      fs;
        logic [23:0]      fe;
        logic [23:0]      st;
        logic [15:0]      dw;
        bit               single;
        int               n;
        logic [7:0][23:0] seq;
    } vec_t;

    vec_t tbl [11];

    function automatic vec_t mk(
        input logic [1:0] m, input logic [23:0] fs, input logic [23:0] fe,
        input logic [23:0] st, input logic [15:0] dw, input bit single, input int n,
        input logic [23:0] s0, input logic [23:0] s1, input logic [23:0] s2,
        input logic [23:0] s3, input logic [23:0] s4, input logic [23:0] s5,
        input logic [23:0] s6, input logic [23:0] s7
    );
        vec_t v;
        v.mode = m; v.fs = fs; v.fe = fe; v.st = st; v.dw = dw;
        v.single = single; v.n = n;
        v.seq = {s7, s6, s5, s4, s3, s2, s1, s0};
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input vec_t v);
        mode = v.mode; fcw_start = v.fs; fcw_stop = v.fe;
        fcw_step = v.st; dwell = v.dw;
    endtask

    task automatic run_vec(input int idx, input vec_t v, input bit disturb);
        int hold;
        hold = (v.dw == 0) ? 1 : int'(v.dw);
        load(v);
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int k = 0; k < v.n; k++) begin
            for (int c = 0; c < hold; c++) begin
                chk($sformatf("v%0d fcw k%0d c%0d", idx, k, c), 32'(fcw), 32'(v.seq[k]));
                chk($sformatf("v%0d tick k%0d c%0d", idx, k, c), 32'(step_tick), 32'(c == 0));
                chk($sformatf("v%0d busy k%0d", idx, k), 32'(busy), 32'd1);
                chk($sformatf("v%0d done k%0d", idx, k), 32'(done), 32'd0);
                start = disturb && k == 1 && c == 0;
                if (start) begin
                    fcw_start = 24'h0F0000; fcw_stop = 24'h000100;
                    fcw_step = 24'h000001; dwell = 16'd9; mode = 2'b10;
                end
                cyc();
                start = 1'b0;
            end
        end
        if (v.single) begin
            chk($sformatf("v%0d done pulse", idx), 32'(done), 32'd1);
            chk($sformatf("v%0d busy end", idx), 32'(busy), 32'd0);
            chk($sformatf("v%0d tick end", idx), 32'(step_tick), 32'd0);
            chk($sformatf("v%0d fcw end", idx), 32'(fcw), 32'(v.seq[v.n-1]));
            cyc();
            chk($sformatf("v%0d done clear", idx), 32'(done), 32'd0);
            chk($sformatf("v%0d fcw hold", idx), 32'(fcw), 32'(v.seq[v.n-1]));
        end else begin
            chk($sformatf("v%0d no done", idx), 32'(done), 32'd0);
            abort = 1'b1;
            cyc();
            abort = 1'b0;
            chk($sformatf("v%0d abort fcw", idx), 32'(fcw), 32'd0);
            chk($sformatf("v%0d abort busy", idx), 32'(busy), 32'd0);
        end
    endtask

    initial begin
        tbl[0]  = mk(2'b00, 24'h010000, 24'h040000, 24'h010000, 16'd4, 1, 4,
                     24'h010000, 24'h020000, 24'h030000, 24'h040000, 0, 0, 0, 0);
        tbl[1]  = mk(2'b00, 24'h07AE14, 24'h100000, 24'h030000, 16'd2, 1, 4,
                     24'h07AE14, 24'h0AAE14, 24'h0DAE14, 24'h100000, 0, 0, 0, 0);
        tbl[2]  = mk(2'b00, 24'h020000, 24'h000000, 24'h030000, 16'd3, 1, 2,
                     24'h020000, 24'h000000, 0, 0, 0, 0, 0, 0);
        tbl[3]  = mk(2'b00, 24'h020000, 24'h000000, 24'h030000, 16'd0, 1, 2,
                     24'h020000, 24'h000000, 0, 0, 0, 0, 0, 0);
        tbl[4]  = mk(2'b10, 24'h010000, 24'h030000, 24'h010000, 16'd1, 0, 8,
                     24'h010000, 24'h020000, 24'h030000, 24'h020000,
                     24'h010000, 24'h020000, 24'h030000, 24'h020000);
        tbl[5]  = mk(2'b01, 24'h010000, 24'h030000, 24'h010000, 16'd1, 0, 8,
                     24'h010000, 24'h020000, 24'h030000, 24'h010000,
                     24'h020000, 24'h030000, 24'h010000, 24'h020000);
        tbl[6]  = mk(2'b00, 24'h010000, 24'h040000, 24'h000000, 16'd2, 1, 2,
                     24'h010000, 24'h040000, 0, 0, 0, 0, 0, 0);
        tbl[7]  = mk(2'b00, 24'h040000, 24'h040000, 24'h010000, 16'd3, 1, 1,
                     24'h040000, 0, 0, 0, 0, 0, 0, 0);
        tbl[8]  = mk(2'b11, 24'h010000, 24'h030000, 24'h010000, 16'd1, 1, 3,
                     24'h010000, 24'h020000, 24'h030000, 0, 0, 0, 0, 0);
        tbl[9]  = mk(2'b10, 24'h050000, 24'h050000, 24'h010000, 16'd2, 0, 4,
                     24'h050000, 24'h050000, 24'h050000, 24'h050000, 0, 0, 0, 0);
        tbl[10] = mk(2'b10, 24'h030000, 24'h010000, 24'h010000, 16'd1, 0, 6,
                     24'h030000, 24'h020000, 24'h010000, 24'h020000,
                     24'h030000, 24'h020000, 0, 0);

        cyc();
        chk("reset fcw", 32'(fcw), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset tick", 32'(step_tick), 32'd0);
        reset = 1'b1;
        cyc();

        foreach (tbl[i]) run_vec(i, tbl[i], 1'b0);

        // start pulse and input changes while busy must not disturb the sweep
        run_vec(100, tbl[0], 1'b1);

        // abort when fcw reaches 0x020000
        load(tbl[0]);
        start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (4) cyc();
        chk("abort pre fcw", 32'(fcw), 32'h020000);
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        chk("abort fcw", 32'(fcw), 32'd0);
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        chk("abort tick", 32'(step_tick), 32'd0);
        for (int i = 0; i < 20; i++) begin
            chk("abort idle done", 32'(done), 32'd0);
            cyc();
        end

        // asynchronous reset mid-sweep
        start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (5) cyc();
        chk("rst pre fcw", 32'(fcw), 32'h020000);
        reset = 1'b0;
        #1;
        chk("rst fcw", 32'(fcw), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        cyc();
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            chk("rst idle done", 32'(done), 32'd0);
            cyc();
        end

        // abort wins over start in the same idle cycle
        start = 1'b1;
        abort = 1'b1;
        cyc();
        start = 1'b0;
        abort = 1'b0;
        chk("abort+start busy", 32'(busy), 32'd0);
        chk("abort+start fcw", 32'(fcw), 32'd0);
        chk("abort+start tick", 32'(step_tick), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
